// File: rtl/twiddle_pkg.sv
// Shared constants and the saturation helper for the twiddle multiplier.
package twiddle_pkg;

  localparam int TW_C_W = 8;
  localparam int TW_S_W = 9;
  localparam int N_FFT  = 16;
  localparam int K_W    = 3;

  // Clamp a signed value to the range of a w-bit signed number.
  function automatic logic signed [31:0] sat_w(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/twiddle_lut.sv
// Twiddle ROMs (C, C+S, C-S) addressed by k; outputs registered as pipeline slot P1.
module twiddle_lut
  import twiddle_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [K_W-1:0]           k,
  output logic signed [TW_C_W-1:0] c_q,
  output logic signed [TW_S_W-1:0] cps_q,
  output logic signed [TW_S_W-1:0] cms_q
);

  logic [15:0]              c_word;
  logic [15:0]              cps_word;
  logic [15:0]              cms_word;
  logic signed [TW_C_W-1:0] c_d;
  logic signed [TW_S_W-1:0] cps_d;
  logic signed [TW_S_W-1:0] cms_d;

  function automatic logic [15:0] sx(input int v);
    return 16'(v);
  endfunction

  // ROM words hold each value sign-extended to 16 bits; only the low bits are used.
  always_comb begin
    c_word   = '0;
    cps_word = '0;
    cms_word = '0;
    case (k)
      3'd0: begin c_word = sx(127);  cps_word = sx(127);  cms_word = sx(127); end
      3'd1: begin c_word = sx(117);  cps_word = sx(68);   cms_word = sx(166); end
      3'd2: begin c_word = sx(90);   cps_word = sx(0);    cms_word = sx(180); end
      3'd3: begin c_word = sx(49);   cps_word = sx(-68);  cms_word = sx(166); end
      3'd4: begin c_word = sx(0);    cps_word = sx(-127); cms_word = sx(127); end
      3'd5: begin c_word = sx(-49);  cps_word = sx(-166); cms_word = sx(68);  end
      3'd6: begin c_word = sx(-90);  cps_word = sx(-180); cms_word = sx(0);   end
      default: begin c_word = sx(-117); cps_word = sx(-166); cms_word = sx(-68); end
    endcase
    c_d   = TW_C_W'(c_word);
    cps_d = TW_S_W'(cps_word);
    cms_d = TW_S_W'(cms_word);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q   <= '0;
      cps_q <= '0;
      cms_q <= '0;
    end else if (en) begin
      c_q   <= c_d;
      cps_q <= cps_d;
      cms_q <= cms_d;
    end
  end

endmodule

// File: rtl/twiddle_cmul3.sv
// Pipelined (a+jb)*W multiplier using three real products; one global stall enable.
module twiddle_cmul3
  import twiddle_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC   = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               stage,
  input  logic                     frame_start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im,
  output logic [K_W-1:0]           out_k,
  output logic                     out_last
);

  localparam int ACC_W = DATA_W + 10;

  // Handshake: a transfer happens on an edge where valid and ready are both 1.
  // Every stage advances only when the output register is empty or being drained.
  logic en;
  logic accept;
  logic [K_W-1:0] j_use;

  logic [K_W-1:0] j_q, j_d;
  // P0
  logic v0_q, v0_d, l0_q, l0_d;
  logic signed [DATA_W-1:0] a0_q, a0_d, b0_q, b0_d;
  logic [K_W-1:0] k0_q, k0_d;
  // P1
  logic v1_q, v1_d, l1_q, l1_d;
  logic signed [DATA_W-1:0] a1_q, a1_d, b1_q, b1_d;
  logic signed [DATA_W:0] d1_q, d1_d;
  logic [K_W-1:0] k1_q, k1_d;
  logic signed [TW_C_W-1:0] c_q;
  logic signed [TW_S_W-1:0] cps_q, cms_q;
  // P2
  logic v2_q, v2_d, l2_q, l2_d;
  logic signed [ACC_W-1:0] m2_q, m2_d, pa2_q, pa2_d, pb2_q, pb2_d;
  logic [K_W-1:0] k2_q, k2_d;
  // P3
  logic v3_q, v3_d, l3_q, l3_d;
  logic signed [DATA_W-1:0] re3_q, re3_d, im3_q, im3_d;
  logic [K_W-1:0] k3_q, k3_d;
  logic signed [ACC_W-1:0] re_full, im_full;
  // output register
  logic out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic signed [DATA_W-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
  logic [K_W-1:0] out_k_q, out_k_d;

  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_k     = out_k_q;
  assign out_last  = out_last_q;

  twiddle_lut u_lut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .k     (k0_q),
    .c_q   (c_q),
    .cps_q (cps_q),
    .cms_q (cms_q)
  );

  always_comb begin
    accept  = in_valid && en;
    j_use   = frame_start ? '0 : j_q;
    j_d     = accept ? j_use + K_W'(1) : j_q;

    v0_d    = in_valid;
    a0_d    = in_re;
    b0_d    = in_im;
    k0_d    = K_W'({{K_W{1'b0}}, j_use} << stage);
    l0_d    = (j_use == K_W'(N_FFT / 2 - 1));

    v1_d    = v0_q;
    a1_d    = a0_q;
    b1_d    = b0_q;
    d1_d    = (DATA_W + 1)'(a0_q) - (DATA_W + 1)'(b0_q);
    k1_d    = k0_q;
    l1_d    = l0_q;

    v2_d    = v1_q;
    m2_d    = ACC_W'(c_q) * ACC_W'(d1_q);
    pb2_d   = ACC_W'(cms_q) * ACC_W'(b1_q);
    pa2_d   = ACC_W'(cps_q) * ACC_W'(a1_q);
    k2_d    = k1_q;
    l2_d    = l1_q;

    re_full = m2_q + pb2_q;
    im_full = pa2_q - m2_q;
    v3_d    = v2_q;
    re3_d   = DATA_W'(sat_w(32'(re_full >>> FRAC), DATA_W));
    im3_d   = DATA_W'(sat_w(32'(im_full >>> FRAC), DATA_W));
    k3_d    = k2_q;
    l3_d    = l2_q;

    out_valid_d = v3_q;
    out_re_d    = re3_q;
    out_im_d    = im3_q;
    out_k_d     = k3_q;
    out_last_d  = l3_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      j_q <= '0;
      v0_q <= 1'b0; l0_q <= 1'b0; a0_q <= '0; b0_q <= '0; k0_q <= '0;
      v1_q <= 1'b0; l1_q <= 1'b0; a1_q <= '0; b1_q <= '0; d1_q <= '0; k1_q <= '0;
      v2_q <= 1'b0; l2_q <= 1'b0; m2_q <= '0; pa2_q <= '0; pb2_q <= '0; k2_q <= '0;
      v3_q <= 1'b0; l3_q <= 1'b0; re3_q <= '0; im3_q <= '0; k3_q <= '0;
      out_valid_q <= 1'b0; out_last_q <= 1'b0;
      out_re_q <= '0; out_im_q <= '0; out_k_q <= '0;
    end else if (en) begin
      j_q <= j_d;
      v0_q <= v0_d; l0_q <= l0_d; a0_q <= a0_d; b0_q <= b0_d; k0_q <= k0_d;
      v1_q <= v1_d; l1_q <= l1_d; a1_q <= a1_d; b1_q <= b1_d; d1_q <= d1_d; k1_q <= k1_d;
      v2_q <= v2_d; l2_q <= l2_d; m2_q <= m2_d; pa2_q <= pa2_d; pb2_q <= pb2_d; k2_q <= k2_d;
      v3_q <= v3_d; l3_q <= l3_d; re3_q <= re3_d; im3_q <= im3_d; k3_q <= k3_d;
      out_valid_q <= out_valid_d; out_last_q <= out_last_d;
      out_re_q <= out_re_d; out_im_q <= out_im_d; out_k_q <= out_k_d;
    end
  end

endmodule

// File: tb/tb_twiddle_cmul3.sv
// Bench for twiddle_cmul3: directed cases, burst, random backpressure and reset flush.
module tb_twiddle_cmul3;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         stage;
  logic               frame_start;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_re, in_im;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_re, out_im;
  logic [2:0]         out_k;
  logic               out_last;

  twiddle_cmul3 #(.DATA_W(16), .FRAC(7)) dut (
    .clk(clk), .rst(rst), .stage(stage), .frame_start(frame_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_k(out_k), .out_last(out_last)
  );

  // ---------------- clock / cycle count
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state
  int checks = 0;
  int failures = 0;
  logic [35:0] exp_q[$];
  int          acc_q[$];
  bit          lat_q[$];
  logic [2:0]  mj = 3'd0;
  bit          lat_chk = 1'b0;
  bit          b2b_chk = 1'b0;
  bit          rand_ready = 1'b0;

  int c_tab[8] = '{127, 117, 90, 49, 0, -49, -90, -117};
  int s_tab[8] = '{0, -49, -90, -117, -127, -117, -90, -49};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic finish_up();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  function automatic logic [15:0] sat16(input longint v);
    if (v > 32767) return 16'h7fff;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  // Reference: (a+jb)(C+jS) = (aC - bS) + j(aS + bC), floor by 2^7, saturate.
  function automatic logic [35:0] model(input logic signed [15:0] a, input logic signed [15:0] b,
                                        input logic [1:0] st, input logic [2:0] j);
    int     kk;
    longint re, im;
    kk = (int'(j) << st) & 7;
    re = longint'(a) * c_tab[kk] - longint'(b) * s_tab[kk];
    im = longint'(a) * s_tab[kk] + longint'(b) * c_tab[kk];
    return {sat16(re >>> 7), sat16(im >>> 7), 3'(kk), (j == 3'd7)};
  endfunction

  // ---------------- driver
  task automatic send(input logic signed [15:0] a, input logic signed [15:0] b,
                      input logic [1:0] st, input logic fs);
    int waited;
    logic [2:0] ju;
    waited = 0;
    in_valid = 1'b1; in_re = a; in_im = b; stage = st; frame_start = fs;
    @(negedge clk);
    if (b2b_chk) check("b2b_in_ready", in_ready, 1);
    while (!in_ready) begin
      waited++;
      if (waited > 500) begin
        check("in_ready_timeout", 0, 1);
        finish_up();
      end
      @(negedge clk);
    end
    ju = fs ? 3'd0 : mj;
    exp_q.push_back(model(a, b, st, ju));
    acc_q.push_back(cyc + 1);
    lat_q.push_back(lat_chk);
    mj = ju + 3'd1;
    @(posedge clk); #1;
    in_valid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // ---------------- random backpressure
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) out_ready = ($urandom_range(0, 99) < 55);
    end
  end

  // ---------------- output monitor
  bit          stall_prev = 1'b0;
  logic [36:0] held;
  always @(negedge clk) begin
    logic [35:0] e;
    int          a;
    bit          l;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) check("hold_stable", {out_valid, out_re, out_im, out_k, out_last}, held);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          l = lat_q.pop_front();
          check("out_data", {out_re, out_im, out_k, out_last}, e);
          if (l) check("latency", cyc - a, 4);
        end
      end
      stall_prev = out_valid && !out_ready;
      held = {out_valid, out_re, out_im, out_k, out_last};
    end
  end

  // ---------------- main sequence
  initial begin
    rst = 1'b1; stage = 2'd0; frame_start = 1'b0; in_valid = 1'b0;
    in_re = '0; in_im = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_re", out_re, 0);
    check("rst_out_im", out_im, 0);
    check("rst_out_k", out_k, 0);
    check("rst_out_last", out_last, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // directed: k=0, k=4, k=2 saturation, each with exact latency
    lat_chk = 1'b1;
    send(16'sd100, 16'sd0, 2'd0, 1'b1);
    wait_drain();
    send(16'sd7, 16'sd3, 2'd2, 1'b1);
    send(16'sd100, 16'sd50, 2'd2, 1'b0);
    wait_drain();
    send(16'sd1, 16'sd1, 2'd1, 1'b1);
    send(16'sd32767, 16'sd32767, 2'd1, 1'b0);
    wait_drain();

    // frame_start without in_valid must not touch the counter (model j stays 2)
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    send(16'sd1000, -16'sd2000, 2'd0, 1'b0);
    wait_drain();

    // 16 back-to-back samples at stage 0
    b2b_chk = 1'b1;
    for (int i = 0; i < 16; i++)
      send(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 2'd0, (i == 0));
    b2b_chk = 1'b0;
    wait_drain();

    // random backpressure, gaps, stage changes and saturation corners
    lat_chk = 1'b0;
    rand_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      logic signed [15:0] a, b;
      repeat ($urandom_range(0, 2)) begin
        frame_start = ($urandom_range(0, 5) == 0);
        @(posedge clk); #1;
      end
      frame_start = 1'b0;
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom_range(0, 1) ? 16'sh7fff : 16'sh8000;
        b = $urandom_range(0, 1) ? 16'sh7fff : 16'sh8000;
      end
      send(a, b, 2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    // reset with three samples in flight
    lat_chk = 1'b1;
    send(16'sd11, 16'sd22, 2'd0, 1'b1);
    send(16'sd33, 16'sd44, 2'd0, 1'b0);
    send(16'sd55, 16'sd66, 2'd0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete(); acc_q.delete(); lat_q.delete();
    mj = 3'd0;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("flush_quiet", out_valid, 0);
    end
    @(posedge clk); #1;
    send(16'sd300, -16'sd200, 2'd1, 1'b0);
    wait_drain();

    finish_up();
  end

  initial begin
    #200000;
    check("global_timeout", 0, 1);
    finish_up();
  end

endmodule
